nn_image_top: RTL and testbench
===============================

NN_IMAGE_TOP -- requirements
Module: nn_image_top

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image width in pixels, at least 3.
REQ-002 SHALL have parameter IMG_H, default 8: image height in pixels, at least 3.
REQ-003 SHALL use these fixed package constants: K_SIZE=3 (kernel size), W_W=8 (FC weight width), RES_W=24 (conv/norm result width), ACC_FC_W=32 (FC product width), SHIFT_NORM=0 (normalisation shift).
REQ-004 One clock; reset is synchronous and active-high; clk input 1 bit is the clock, and rst input 1 bit is the reset.
REQ-005 in_valid, input, 1 bit: qualifies in_pixel; pixels arrive in raster order.
REQ-006 in_pixel, input, 9 bits, signed.
REQ-007 k00..k22, inputs, 8 bits each, signed: 3x3 kernel, with krc = kernel row r, column c.
REQ-008 bias, scale and offset, inputs, 8 bits each, signed.
REQ-009 w0, w1 and w2, inputs, W_W bits each, signed: FC weights.
REQ-010 out_valid, output, 1 bit: one-cycle strobe per valid window.
REQ-011 conv_result and norm_result, outputs, RES_W bits each, signed.
REQ-012 acc0, acc1 and acc2, outputs, ACC_FC_W bits each, signed.
REQ-013 out_x, output, $clog2(IMG_W) bits, and out_y, output, $clog2(IMG_H) bits: top-left coordinate of the output window.

Function
REQ-014 SHALL keep column and row counters. The column counter advances only on a cycle with in_valid=1. It wraps at IMG_W-1 and then increments the row counter. The row counter wraps at IMG_H-1, so the next frame starts at (0,0).
REQ-015 SHALL buffer the two previous rows (line buffers) plus a 3x3 shift window. A window is complete when an accepted pixel has col>=2 and row>=2.
REQ-016 For a complete window whose pixel p[y][x] has top-left (x-2, y-2), the block SHALL compute sum9 = sum over r,c of p[y-2+r][x-2+c]*krc, at full precision.
REQ-017 SHALL compute conv = (sum9 <<< 1) + bias, delivered on RES_W bits.
REQ-018 SHALL compute prod = conv*scale at full precision.
REQ-019 SHALL shift prod arithmetically right by SHIFT_NORM when it is positive, left by -SHIFT_NORM when it is negative, and not at all when it is 0.
REQ-020 SHALL compute s = shifted + offset, then norm = (s<0) ? 0 : s (ReLU).
REQ-021 SHALL compute accN = norm*wN for N=0,1,2. Each is a per-window product, not a running sum.
REQ-022 Pipeline latency SHALL be fixed. The completing pixel is sampled at edge N; out_valid and all results are registered and visible after edge N+2.
REQ-023 The pipeline SHALL have no stall. Idle in_valid=0 cycles SHALL insert bubbles with out_valid=0 and SHALL NOT alter results.
REQ-024 Windows SHALL never straddle a row or a frame boundary; exactly (IMG_W-2)*(IMG_H-2) strobes per frame, emitted in raster order.
REQ-025 Results, out_x and out_y SHALL hold their values while out_valid=0.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL clear counters, the window valid tags, the pipeline valid bits and all outputs to 0.
REQ-027 Line-buffer contents need not be cleared.
REQ-028 Reset mid-frame SHALL abort the frame; the next accepted pixel is (0,0).

Configuration
REQ-029 Macro NN_NORM_SAT_EN, when defined, SHALL saturate norm to the RES_W signed maximum if s exceeds it.
REQ-030 When NN_NORM_SAT_EN is undefined, norm SHALL be the low RES_W bits of s (wrap).
REQ-031 With or without NN_NORM_SAT_EN, the acc outputs SHALL use the post-saturation or post-wrap norm value.

Verification
REQ-032 Image 1..64 (8x8) raster, kernel all 1, bias 0, scale 1, offset 0, w=1/2/3 -> 36 strobes. First strobe is (0,0): conv=180, norm=180, acc=180/360/540. Last strobe is (5,5): conv=990, norm=990, acc=990/1980/2970.
REQ-033 Same image, kernel all -1 -> conv[0,0]=-180, norm=0, acc=0/0/0 for all 36 windows.
REQ-034 Same image, kernel all 1, bias=5, scale=2, offset=-10 -> at (0,0): conv=185, norm=360, acc0=360.
REQ-035 Same as REQ-032 with 3 idle cycles after every 5th pixel -> identical 36 results and coordinates; out_valid is 0 during the bubbles.
REQ-036 Assert rst after 20 pixels, then stream the full image -> exactly 36 strobes, matching REQ-032. Then stream two frames back to back -> 72 strobes, with the second frame's coordinates restarting at (0,0).
REQ-037 With NN_NORM_SAT_EN defined: kernel all 127, pixels all 255, scale=127 -> norm=8388607.

Source files
------------

// File: rtl/nn_image_top.sv
// Streaming 3x3 convolution, scale/offset/ReLU normalisation and 3-way FC products, fixed 2-cycle latency.
// Build option: define NN_NORM_SAT_EN to clamp norm at the RES_W signed maximum (default wraps).
package nn_image_pkg;
  localparam int K_SIZE     = 3;
  localparam int W_W        = 8;
  localparam int RES_W      = 24;
  localparam int ACC_FC_W   = 32;
  localparam int SHIFT_NORM = 0;
endpackage

module nn_image_top
  import nn_image_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [8:0]             in_pixel,
  input  logic signed [7:0]             k00,
  input  logic signed [7:0]             k01,
  input  logic signed [7:0]             k02,
  input  logic signed [7:0]             k10,
  input  logic signed [7:0]             k11,
  input  logic signed [7:0]             k12,
  input  logic signed [7:0]             k20,
  input  logic signed [7:0]             k21,
  input  logic signed [7:0]             k22,
  input  logic signed [7:0]             bias,
  input  logic signed [7:0]             scale,
  input  logic signed [7:0]             offset,
  input  logic signed [W_W-1:0]         w0,
  input  logic signed [W_W-1:0]         w1,
  input  logic signed [W_W-1:0]         w2,
  output logic                          out_valid,
  output logic signed [RES_W-1:0]       conv_result,
  output logic signed [RES_W-1:0]       norm_result,
  output logic signed [ACC_FC_W-1:0]    acc0,
  output logic signed [ACC_FC_W-1:0]    acc1,
  output logic signed [ACC_FC_W-1:0]    acc2,
  output logic [$clog2(IMG_W)-1:0]      out_x,
  output logic [$clog2(IMG_H)-1:0]      out_y
);

  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int PIX_W  = 9;
  localparam int SUM_W  = PIX_W + 8 + 4;
  localparam int PROD_W = RES_W + 8;
  localparam int SH_ABS = (SHIFT_NORM < 0) ? -SHIFT_NORM : SHIFT_NORM;
  localparam int SHF_W  = PROD_W + SH_ABS;
  localparam int S_W    = SHF_W + 1;
  localparam logic signed [S_W-1:0] NORM_MAX = S_W'((2 ** (RES_W - 1)) - 1);

`ifdef NN_NORM_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [XW-1:0]             r_col;
  logic [YW-1:0]             r_row;
  logic signed [PIX_W-1:0]   r_lb1 [IMG_W];
  logic signed [PIX_W-1:0]   r_lb2 [IMG_W];
  logic signed [PIX_W-1:0]   r_win [K_SIZE][K_SIZE];
  logic                      r_va;
  logic [XW-1:0]             r_xa;
  logic [YW-1:0]             r_ya;
  logic                      r_vb;
  logic signed [RES_W-1:0]   r_conv_b;
  logic [XW-1:0]             r_xb;
  logic [YW-1:0]             r_yb;

  logic signed [7:0]         w_k [K_SIZE][K_SIZE];
  logic signed [SUM_W-1:0]   w_sum9;
  logic signed [RES_W-1:0]   w_conv;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SHF_W-1:0]   w_shf;
  logic signed [S_W-1:0]     w_s;
  logic signed [RES_W-1:0]   w_norm;

  // Line buffers and window hold pixel data only; the valid tags below gate their use.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_pixel;
      for (int r = 0; r < K_SIZE; r++)
        for (int c = 0; c < K_SIZE - 1; c++)
          r_win[r][c] <= r_win[r][c+1];
      r_win[0][K_SIZE-1] <= r_lb2[r_col];
      r_win[1][K_SIZE-1] <= r_lb1[r_col];
      r_win[2][K_SIZE-1] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_va  <= 1'b0;
      r_xa  <= '0;
      r_ya  <= '0;
    end else begin
      r_va <= 1'b0;
      if (in_valid) begin
        r_va <= (r_col >= XW'(2)) && (r_row >= YW'(2));
        r_xa <= r_col - XW'(2);
        r_ya <= r_row - YW'(2);
        if (r_col == XW'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == YW'(IMG_H - 1)) ? '0 : r_row + YW'(1);
        end else begin
          r_col <= r_col + XW'(1);
        end
      end
    end
  end

  always_comb begin
    w_k[0][0] = k00; w_k[0][1] = k01; w_k[0][2] = k02;
    w_k[1][0] = k10; w_k[1][1] = k11; w_k[1][2] = k12;
    w_k[2][0] = k20; w_k[2][1] = k21; w_k[2][2] = k22;
  end

  always_comb begin
    w_sum9 = '0;
    for (int r = 0; r < K_SIZE; r++)
      for (int c = 0; c < K_SIZE; c++)
        w_sum9 = w_sum9 + SUM_W'(r_win[r][c]) * SUM_W'(w_k[r][c]);
    w_conv = (RES_W'(w_sum9) <<< 1) + RES_W'(bias);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vb     <= 1'b0;
      r_conv_b <= '0;
      r_xb     <= '0;
      r_yb     <= '0;
    end else begin
      r_vb <= r_va;
      if (r_va) begin
        r_conv_b <= w_conv;
        r_xb     <= r_xa;
        r_yb     <= r_ya;
      end
    end
  end

  // Positive SHIFT_NORM shifts right, negative shifts left; the widened product keeps left shifts exact.
  always_comb begin
    w_prod = PROD_W'(r_conv_b) * PROD_W'(scale);
    w_shf  = SHF_W'(w_prod);
    if (SHIFT_NORM > 0)
      w_shf = w_shf >>> SH_ABS;
    else if (SHIFT_NORM < 0)
      w_shf = w_shf <<< SH_ABS;
    w_s = S_W'(w_shf) + S_W'(offset);
    if (w_s[S_W-1])
      w_norm = '0;
    else if (SAT_EN && (w_s > NORM_MAX))
      w_norm = NORM_MAX[RES_W-1:0];
    else
      w_norm = w_s[RES_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      conv_result <= '0;
      norm_result <= '0;
      acc0        <= '0;
      acc1        <= '0;
      acc2        <= '0;
      out_x       <= '0;
      out_y       <= '0;
    end else begin
      out_valid <= r_vb;
      if (r_vb) begin
        conv_result <= r_conv_b;
        norm_result <= w_norm;
        acc0        <= ACC_FC_W'(w_norm) * ACC_FC_W'(w0);
        acc1        <= ACC_FC_W'(w_norm) * ACC_FC_W'(w1);
        acc2        <= ACC_FC_W'(w_norm) * ACC_FC_W'(w2);
        out_x       <= r_xb;
        out_y       <= r_yb;
      end
    end
  end

endmodule

// File: tb/tb_nn_image_top.sv
// Bench for nn_image_top: directed frames with a scoreboard of model results checked on every strobe.
module tb_nn_image_top;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [8:0] in_pixel = '0;
  logic signed [7:0] k00, k01, k02, k10, k11, k12, k20, k21, k22;
  logic signed [7:0] bias, scale, offset, w0, w1, w2;
  logic out_valid;
  logic signed [23:0] conv_result, norm_result;
  logic signed [31:0] acc0, acc1, acc2;
  logic [2:0] out_x, out_y;

  always #5 clk = ~clk;

  nn_image_top #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .k00(k00), .k01(k01), .k02(k02), .k10(k10), .k11(k11), .k12(k12),
    .k20(k20), .k21(k21), .k22(k22),
    .bias(bias), .scale(scale), .offset(offset), .w0(w0), .w1(w1), .w2(w2),
    .out_valid(out_valid), .conv_result(conv_result), .norm_result(norm_result),
    .acc0(acc0), .acc1(acc1), .acc2(acc2), .out_x(out_x), .out_y(out_y)
  );

  typedef struct packed {
    logic [23:0] conv;
    logic [23:0] norm;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  x;
    logic [2:0]  y;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } item_t;

  item_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_strobe = 0;
  int img [IMG_H][IMG_W];
  int kern [3][3];
  int b_v, s_v, o_v;
  int w_v [3];
  int bx = 0, by = 0;
  bit sat_en;
  res_t first_obs, last_obs, hold_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(int x, int y);
    longint sum, conv, s, nrm, ns;
    res_t e;
    sum = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum += longint'(img[y+r][x+c]) * longint'(kern[r][c]);
    conv = sum * 2 + b_v;
    s = conv * s_v + o_v;
    if (s < 0) nrm = 0;
    else if (sat_en && s > 64'sd8388607) nrm = 8388607;
    else nrm = s % 64'sd16777216;
    ns = (nrm >= 64'sd8388608) ? nrm - 64'sd16777216 : nrm;
    e.conv = 24'(conv);
    e.norm = 24'(nrm);
    e.a0 = 32'(ns * w_v[0]);
    e.a1 = 32'(ns * w_v[1]);
    e.a2 = 32'(ns * w_v[2]);
    e.x = 3'(x);
    e.y = 3'(y);
    return e;
  endfunction

  always @(negedge clk) begin
    res_t obs;
    item_t it;
    obs = {conv_result, norm_result, acc0, acc1, acc2, out_x, out_y};
    if (rst) begin
      hold_exp = '0;
    end else if (out_valid) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_strobe got x=%0d y=%0d want no strobe", out_x, out_y);
      end
      if (q.size() > 0) begin
        it = q.pop_front();
        checks++;
        assert ({obs.conv, obs.norm, obs.a0, obs.a1, obs.a2} === {it.r.conv, it.r.norm, it.r.a0, it.r.a1, it.r.a2}) else begin
          errors++;
          $error("FAIL data x=%0d y=%0d got conv=%h norm=%h acc=%h/%h/%h want conv=%h norm=%h acc=%h/%h/%h",
                 it.r.x, it.r.y, obs.conv, obs.norm, obs.a0, obs.a1, obs.a2,
                 it.r.conv, it.r.norm, it.r.a0, it.r.a1, it.r.a2);
        end
        checks++;
        assert ({obs.x, obs.y} === {it.r.x, it.r.y}) else begin
          errors++;
          $error("FAIL coord got (%0d,%0d) want (%0d,%0d)", obs.x, obs.y, it.r.x, it.r.y);
        end
        checks++;
        assert (cyc === it.cyc) else begin
          errors++;
          $error("FAIL latency got cycle %0d want cycle %0d", cyc, it.cyc);
        end
        hold_exp = it.r;
      end
      if (n_strobe == 0) first_obs = obs;
      last_obs = obs;
      n_strobe++;
    end else begin
      checks++;
      assert (obs === hold_exp) else begin
        errors++;
        $error("FAIL hold got %h want %h", obs, hold_exp);
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic apply_cfg();
    k00 = 8'(kern[0][0]); k01 = 8'(kern[0][1]); k02 = 8'(kern[0][2]);
    k10 = 8'(kern[1][0]); k11 = 8'(kern[1][1]); k12 = 8'(kern[1][2]);
    k20 = 8'(kern[2][0]); k21 = 8'(kern[2][1]); k22 = 8'(kern[2][2]);
    bias = 8'(b_v); scale = 8'(s_v); offset = 8'(o_v);
    w0 = 8'(w_v[0]); w1 = 8'(w_v[1]); w2 = 8'(w_v[2]);
  endtask

  task automatic set_cfg(int k, int b, int s, int o, int wa, int wb, int wc);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        kern[r][c] = k;
    b_v = b; s_v = s; o_v = o;
    w_v[0] = wa; w_v[1] = wb; w_v[2] = wc;
    apply_cfg();
  endtask

  task automatic pix(int v);
    item_t it;
    img[by][bx] = v;
    in_valid = 1'b1;
    in_pixel = 9'(v);
    if (bx >= 2 && by >= 2) begin
      it.r = model(bx - 2, by - 2);
      it.cyc = cyc + 3;
      q.push_back(it);
    end
    if (bx == IMG_W - 1) begin
      bx = 0;
      by = (by == IMG_H - 1) ? 0 : by + 1;
    end else begin
      bx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic seq_frame(bit bubbles);
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      pix(i + 1);
      if (bubbles && (i % 5 == 4)) idle(3);
    end
  endtask

  task automatic drain(string tag, int want);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    idle(3);
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    chk({tag, "_strobes"}, 64'(n_strobe), 64'(want));
    q.delete();
  endtask

  task automatic chk_first_last(string tag);
    chk({tag, "_first_conv"}, 64'(first_obs.conv), 64'd180);
    chk({tag, "_first_norm"}, 64'(first_obs.norm), 64'd180);
    chk({tag, "_first_acc"}, {first_obs.a0, first_obs.a1}, {32'd180, 32'd360});
    chk({tag, "_first_acc2"}, 64'(first_obs.a2), 64'd540);
    chk({tag, "_first_xy"}, 64'({first_obs.x, first_obs.y}), 64'd0);
    chk({tag, "_last_conv"}, 64'(last_obs.conv), 64'd990);
    chk({tag, "_last_norm"}, 64'(last_obs.norm), 64'd990);
    chk({tag, "_last_acc"}, {last_obs.a0, last_obs.a1}, {32'd990, 32'd1980});
    chk({tag, "_last_acc2"}, 64'(last_obs.a2), 64'd2970);
    chk({tag, "_last_xy"}, 64'({last_obs.x, last_obs.y}), 64'({3'd5, 3'd5}));
  endtask

  initial begin
`ifdef NN_NORM_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    set_cfg(1, 0, 1, 0, 1, 2, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_conv", 64'(conv_result), 64'd0);
    chk("rst_norm", 64'(norm_result), 64'd0);
    chk("rst_acc0", 64'(acc0), 64'd0);
    chk("rst_acc1", 64'(acc1), 64'd0);
    chk("rst_acc2", 64'(acc2), 64'd0);
    chk("rst_xy", 64'({out_x, out_y}), 64'd0);
    rst = 1'b0;

    // plain frame, kernel of ones
    n_strobe = 0;
    seq_frame(1'b0);
    drain("ones", 36);
    chk_first_last("ones");

    // negative kernel, ReLU clamps everything
    set_cfg(-1, 0, 1, 0, 1, 2, 3);
    n_strobe = 0;
    seq_frame(1'b0);
    drain("neg", 36);
    chk("neg_first_conv", 64'(first_obs.conv), 64'(24'hFFFF4C));
    chk("neg_first_norm", 64'(first_obs.norm), 64'd0);
    chk("neg_first_acc0", 64'(first_obs.a0), 64'd0);

    // bias, scale and offset
    set_cfg(1, 5, 2, -10, 1, 2, 3);
    n_strobe = 0;
    seq_frame(1'b0);
    drain("bso", 36);
    chk("bso_first_conv", 64'(first_obs.conv), 64'd185);
    chk("bso_first_norm", 64'(first_obs.norm), 64'd360);
    chk("bso_first_acc0", 64'(first_obs.a0), 64'd360);

    // idle bubbles every 5th pixel
    set_cfg(1, 0, 1, 0, 1, 2, 3);
    n_strobe = 0;
    seq_frame(1'b1);
    drain("bubble", 36);
    chk_first_last("bubble");

    // mid-frame reset aborts, then one frame and two back-to-back frames
    n_strobe = 0;
    for (int i = 0; i < 20; i++) pix(i + 1);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    bx = 0;
    by = 0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    idle(2);
    chk("midrst_strobes", 64'(n_strobe), 64'd0);
    seq_frame(1'b0);
    drain("after_rst", 36);
    chk_first_last("after_rst");
    n_strobe = 0;
    seq_frame(1'b0);
    seq_frame(1'b0);
    drain("two_frames", 72);
    chk("two_frames_last_xy", 64'({last_obs.x, last_obs.y}), 64'({3'd5, 3'd5}));

    // random kernel, image and coefficients
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        kern[r][c] = int'($urandom_range(255)) - 128;
    b_v = int'($urandom_range(255)) - 128;
    s_v = int'($urandom_range(255)) - 128;
    o_v = int'($urandom_range(255)) - 128;
    for (int i = 0; i < 3; i++) w_v[i] = int'($urandom_range(255)) - 128;
    apply_cfg();
    n_strobe = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) pix(int'($urandom_range(510)) - 255);
    drain("random", 36);

    // large positive s: saturates with NN_NORM_SAT_EN, wraps without
    set_cfg(127, 0, 127, 0, 1, 1, 1);
    n_strobe = 0;
    for (int i = 0; i < IMG_W * IMG_H; i++) pix(255);
    drain("big", 36);
    chk("big_conv", 64'(first_obs.conv), 64'd582930);
    chk("big_norm", 64'(first_obs.norm), sat_en ? 64'd8388607 : 64'd6923246);
    chk("big_acc0", 64'(first_obs.a0), sat_en ? 64'd8388607 : 64'd6923246);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
